alu_writeback_stage: RTL and testbench

- Registered execute-to-writeback stage directly downstream of the ALU.
- Captures each ALU result with its destination register and write/flag enables into a 2-entry skid FIFO.
- Presents entries in order to the register-file write port with a valid/ready handshake, and updates the architectural status flags on retire.
- Provides a combinational forwarding lookup so operand fetch can bypass results that have not yet been written back.

---
 rtl/alu_writeback_stage_pkg.sv | 22 ++
 rtl/alu_writeback_stage_if.sv | 29 ++
 rtl/alu_writeback_stage_wb_flag_gen.sv | 16 +
 rtl/alu_writeback_stage.sv | 111 +++++++++++
 tb/tb_alu_writeback_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared constants and the writeback entry type for the execute/writeback boundary.
// The regfile and hazard unit import the same entry layout.
package alu_writeback_stage_pkg;

    localparam int WORD_SIZE  = 19;
    localparam int REG_ADDR_W = 4;
    localparam int DEPTH      = 2;

    localparam int FLAG_W = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_P = 0;

    typedef struct packed {
        logic [WORD_SIZE-1:0]  result;
        logic [REG_ADDR_W-1:0] dest;
        logic                  we;
        logic                  flag_en;
        logic [FLAG_W-1:0]     flags;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU, the writeback stage and the register-file write port.
// The master side is the environment: it drives ALU results and register-file readiness.
interface alu_writeback_stage_if;
    import alu_writeback_stage_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_SIZE-1:0]  in_result;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  in_we;
    logic                  in_flag_en;

    logic                  wb_valid;
    logic                  wb_ready;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [WORD_SIZE-1:0]  wb_data;

    modport master (
        output in_valid, in_result, in_dest, in_we, in_flag_en, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  in_valid, in_result, in_dest, in_we, in_flag_en, wb_ready,
        output in_ready, wb_valid, wb_we, wb_addr, wb_data
    );

endinterface

// File: rtl/alu_writeback_stage_wb_flag_gen.sv
// Combinational {Z,N,P} status flags for one datapath word.
module wb_flag_gen
    import alu_writeback_stage_pkg::*;
(
    input  logic [WORD_SIZE-1:0] word,
    output logic [FLAG_W-1:0]    flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (word == '0);
        flags[FLAG_N] = word[WORD_SIZE-1];
        flags[FLAG_P] = ~^word;
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback stage: 2-entry skid FIFO feeding the register-file write port,
// architectural flag update on retire, and a combinational forwarding lookup.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    alu_writeback_stage_if.slave    bus,
    input  logic                    flush,
    output logic [FLAG_W-1:0]       flags,
    input  logic [REG_ADDR_W-1:0]   fwd_addr,
    output logic                    fwd_hit,
    output logic [WORD_SIZE-1:0]    fwd_data
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    wb_entry_t         entries [DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              ready_q;
    logic [FLAG_W-1:0] in_flags;
    wb_entry_t         new_entry;
    wb_entry_t         head;
    wb_entry_t         young;
    logic              accept;
    logic              retire;

    wb_flag_gen u_flag_gen (
        .word  (bus.in_result),
        .flags (in_flags)
    );

    always_comb begin
        new_entry         = '0;
        new_entry.result  = bus.in_result;
        new_entry.dest    = bus.in_dest;
        new_entry.we      = bus.in_we;
        new_entry.flag_en = bus.in_flag_en;
        new_entry.flags   = in_flags;
    end

    assign head   = entries[rd_ptr];
    assign young  = entries[rd_ptr + 1'b1];
    assign accept = bus.in_valid & ready_q & ~flush;
    assign retire = (count != 2'd0) & bus.wb_ready & ~flush;

    always_comb begin
        count_next = count;
        case ({accept, retire})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // in_ready is a flop so it never sees wb_ready; a full FIFO stays closed for the retire cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b1;
            flags   <= '0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b1;
        end else begin
            if (accept) begin
                entries[wr_ptr] <= new_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head.flag_en) begin
                    flags <= head.flags;
                end
            end
            count   <= count_next;
            ready_q <= (count_next != FULL);
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.wb_valid = (count != 2'd0);
    assign bus.wb_we    = bus.wb_valid ? head.we     : 1'b0;
    assign bus.wb_addr  = bus.wb_valid ? head.dest   : '0;
    assign bus.wb_data  = bus.wb_valid ? head.result : '0;

    // The younger entry is checked last so it overrides an older match to the same register.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if ((count != 2'd0) && head.we && (head.dest == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = head.result;
        end
        if ((count == FULL) && young.we && (young.dest == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = young.result;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the stage.
module tb_alu_writeback_stage;
    import alu_writeback_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [FLAG_W-1:0]     flags;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic                  fwd_hit;
    logic [WORD_SIZE-1:0]  fwd_data;

    alu_writeback_stage_if bus ();

    alu_writeback_stage dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .flush    (flush),
        .flags    (flags),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned result;
        int unsigned dest;
        bit          we;
        bit          flag_en;
    } model_entry_t;

    model_entry_t q[$];
    int unsigned  m_flags = 0;
    int           checks  = 0;
    int           errors  = 0;

    function automatic int unsigned ref_flags(int unsigned r);
        int unsigned z, n, p;
        z = (r == 0) ? 1 : 0;
        n = (r >= 32'h40000) ? 1 : 0;
        p = (($countones(r) % 2) == 0) ? 1 : 0;
        return z * 4 + n * 2 + p;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_model();
        bit          hit  = 0;
        int unsigned data = 0;
        bit          busy = (q.size() != 0);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].we && q[i].dest == fwd_addr) begin
                hit  = 1;
                data = q[i].result;
                break;
            end
        end
        check_output("in_ready", bus.in_ready, q.size() != 2);
        check_output("wb_valid", bus.wb_valid, busy);
        check_output("wb_we",    bus.wb_we,    busy ? q[0].we : 0);
        check_output("wb_addr",  bus.wb_addr,  busy ? q[0].dest : 0);
        check_output("wb_data",  bus.wb_data,  busy ? q[0].result : 0);
        check_output("flags",    flags,        m_flags);
        check_output("fwd_hit",  fwd_hit,      hit);
        check_output("fwd_data", fwd_data,     data);
    endtask

    task automatic model_step();
        bit acc, ret;
        if (flush) begin
            q.delete();
        end else begin
            acc = bus.in_valid && (q.size() < 2);
            ret = (q.size() > 0) && bus.wb_ready;
            if (ret) begin
                if (q[0].flag_en) m_flags = ref_flags(q[0].result);
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back('{result: bus.in_result, dest: bus.in_dest,
                              we: bus.in_we, flag_en: bus.in_flag_en});
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit v, input int unsigned res, input int unsigned dest,
                                  input bit we, input bit fe, input bit wbr, input bit fl,
                                  input int unsigned fa);
        bus.in_valid   = v;
        bus.in_result  = res[WORD_SIZE-1:0];
        bus.in_dest    = dest[REG_ADDR_W-1:0];
        bus.in_we      = we;
        bus.in_flag_en = fe;
        bus.wb_ready   = wbr;
        flush          = fl;
        fwd_addr       = fa[REG_ADDR_W-1:0];
        run_cycle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        fwd_addr       = '0;
        bus.in_valid   = 1'b0;
        bus.in_result  = '0;
        bus.in_dest    = '0;
        bus.in_we      = 1'b0;
        bus.in_flag_en = 1'b0;
        bus.wb_ready   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rst_in_ready", bus.in_ready, 1);
        check_output("rst_wb_valid", bus.wb_valid, 0);
        check_output("rst_flags",    flags,        0);
        check_output("rst_fwd_hit",  fwd_hit,      0);
        @(posedge clk);
        #1;

        // Zero result retires and sets Z and P.
        apply_stimulus(1, 0, 3, 1, 1, 1, 0, 3);
        check_output("t1_wb_valid", bus.wb_valid, 1);
        check_output("t1_wb_addr",  bus.wb_addr,  3);
        check_output("t1_wb_data",  bus.wb_data,  0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 3);
        check_output("t1_flags", flags, 3'b101);

        // Fill while stalled; youngest match forwards; push while full ignored.
        apply_stimulus(1, 'h40001, 5, 1, 1, 0, 0, 5);
        apply_stimulus(1, 'h00007, 5, 1, 1, 0, 0, 5);
        check_output("t2_in_ready", bus.in_ready, 0);
        check_output("t2_fwd_hit",  fwd_hit,      1);
        check_output("t2_fwd_data", fwd_data,     'h7);
        apply_stimulus(1, 'h12345, 9, 1, 1, 0, 0, 9);
        check_output("t2_full_head", bus.wb_data, 'h40001);
        check_output("t2_full_drop", fwd_hit,     0);

        // Drain in order.
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 5);
        check_output("t3_flags1",   flags,        3'b011);
        check_output("t3_in_ready", bus.in_ready, 1);
        check_output("t3_head2",    bus.wb_data,  'h7);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 5);
        check_output("t3_flags2", flags,        3'b000);
        check_output("t3_empty",  bus.wb_valid, 0);

        // Compare-style entry: no write, no forward, flags still update.
        apply_stimulus(1, 0, 2, 1, 1, 0, 0, 6);
        apply_stimulus(1, 1, 6, 0, 1, 0, 0, 6);
        check_output("t4_fwd_hit", fwd_hit, 0);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 6);
        check_output("t4_flags1", flags,       3'b101);
        check_output("t4_wb_we",  bus.wb_we,   0);
        check_output("t4_wb_data", bus.wb_data, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 6);
        check_output("t4_flags2", flags, 3'b000);

        // Flush with in_valid and wb_ready both high: nothing accepted or retired.
        apply_stimulus(1, 'h40001, 7, 1, 1, 0, 0, 7);
        apply_stimulus(1, 0, 8, 1, 1, 0, 0, 7);
        check_output("t5_pre_hit", fwd_hit, 1);
        apply_stimulus(1, 'h55, 7, 1, 1, 1, 1, 7);
        check_output("t5_wb_valid", bus.wb_valid, 0);
        check_output("t5_fwd_hit",  fwd_hit,      0);
        check_output("t5_flags",    flags,        3'b000);
        check_output("t5_in_ready", bus.in_ready, 1);

        // Asynchronous reset with one entry pending and nonzero flags.
        apply_stimulus(1, 0, 4, 1, 1, 1, 0, 4);
        apply_stimulus(1, 3, 4, 1, 1, 1, 0, 4);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 4);
        check_output("t6_pre_flags", flags,        3'b101);
        check_output("t6_pre_valid", bus.wb_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        m_flags = 0;
        check_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("t6_in_ready", bus.in_ready, 1);
        check_output("t6_wb_valid", bus.wb_valid, 0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            r = ($urandom_range(0, 3) == 0) ? 0 : ($urandom & 32'h7FFFF);
            apply_stimulus($urandom_range(0, 3) != 0, r, $urandom_range(0, 15),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 15));
        end
        @(negedge clk);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
